// File: rtl/rxfis_fetch_if.sv
// rxfis_fetch_if: receive-FIFO read side, DMA payload stream, register-FIS write port and frame status
//   master: driven by rxfis_fetch (pops FIFO, produces payload/register writes/status)
//   slave : the surrounding FIFO, DMA engine and command layer
interface rxfis_fetch_if #(
  parameter int C_CNT_W = 16
) ();
  logic [31:0]        rxfifo_data;
  logic               rxfifo_sof;
  logic               rxfifo_eof;
  logic               rxfifo_empty;
  logic               rxfifo_eof_rdy;
  logic               rxfifo_rd_en;
  logic [31:0]        dat_data;
  logic               dat_valid;
  logic               dat_last;
  logic               dat_ready;
  logic               reg_we;
  logic [2:0]         reg_addr;
  logic [31:0]        reg_wdata;
  logic [7:0]         fis_type;
  logic [3:0]         fis_len;
  logic               fis_done;
  logic               fis_err;
  logic [C_CNT_W-1:0] fis_cnt;
  logic [C_CNT_W-1:0] err_cnt;
  modport master (
    input  rxfifo_data, rxfifo_sof, rxfifo_eof, rxfifo_empty, rxfifo_eof_rdy, dat_ready,
    output rxfifo_rd_en, dat_data, dat_valid, dat_last, reg_we, reg_addr, reg_wdata,
           fis_type, fis_len, fis_done, fis_err, fis_cnt, err_cnt
  );
  modport slave (
    output rxfifo_data, rxfifo_sof, rxfifo_eof, rxfifo_empty, rxfifo_eof_rdy, dat_ready,
    input  rxfifo_rd_en, dat_data, dat_valid, dat_last, reg_we, reg_addr, reg_wdata,
           fis_type, fis_len, fis_done, fis_err, fis_cnt, err_cnt
  );
endinterface

// File: rtl/rxfis_fetch.sv
// rxfis_fetch: frame-level consumer of the SATA receive FIFO; data FIS payload goes to the DMA stream,
// every other FIS type is written into the register-FIS buffer.
//   sys_clk/sys_rst_n : clock, asynchronous active-low reset
//   flush             : discard all FIFO contents
//   bus (master)      : FIFO read port, dat_* valid/ready stream, reg_* write port, fis_* status and counters
module rxfis_fetch #(
  parameter int         C_REG_DEPTH = 7,
  parameter logic [7:0] C_DATA_TYPE = 8'h46,
  parameter int         C_CNT_W     = 16
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  input logic           flush,
  rxfis_fetch_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, REG, DROP, FLUSH} state_t;
  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               reg_we_q, reg_we_d;
  logic [2:0]         reg_addr_q, reg_addr_d;
  logic [31:0]        reg_wdata_q, reg_wdata_d;
  logic [7:0]         fis_type_q, fis_type_d;
  logic [3:0]         fis_len_q, fis_len_d;
  logic               fis_done_q, fis_done_d;
  logic               fis_err_q, fis_err_d;
  logic [C_CNT_W-1:0] fis_cnt_q, fis_cnt_d;
  logic [C_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic               empty, sof, eof, dat_valid, idx_full;
  assign empty     = bus.rxfifo_empty;
  assign sof       = bus.rxfifo_sof;
  assign eof       = bus.rxfifo_eof;
  assign idx_full  = idx_q == 4'(C_REG_DEPTH);
  // a sof at the head while inside a frame marks truncation, so it is never offered as payload
  assign dat_valid = state_q == DATA && !empty && !sof;
  assign bus.rxfifo_rd_en = state_q == DATA ? dat_valid && bus.dat_ready :
                            state_q == REG  ? !empty && !sof && !idx_full :
                            (state_q == HDR || state_q == DROP || state_q == FLUSH) ? !empty : 1'b0;
  assign bus.dat_valid = dat_valid;
  assign bus.dat_data  = bus.rxfifo_data;
  assign bus.dat_last  = eof;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.fis_type  = fis_type_q;
  assign bus.fis_len   = fis_len_q;
  assign bus.fis_done  = fis_done_q;
  assign bus.fis_err   = fis_err_q;
  assign bus.fis_cnt   = fis_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = bus.rxfifo_data;
    fis_type_d  = fis_type_q;
    fis_len_d   = fis_len_q;
    fis_done_d  = 1'b0;
    fis_err_d   = 1'b0;
    case (state_q)
      IDLE: state_d = bus.rxfifo_eof_rdy && !empty ? HDR : IDLE;
      HDR: if (!empty) begin
        if (!sof) begin
          fis_err_d = 1'b1;
          state_d   = eof ? IDLE : DROP;
        end else begin
          fis_type_d = bus.rxfifo_data[7:0];
          if (bus.rxfifo_data[7:0] == C_DATA_TYPE) begin
            fis_err_d = eof;
            state_d   = eof ? IDLE : DATA;
          end else begin
            reg_we_d   = 1'b1;
            reg_addr_d = 3'd0;
            idx_d      = 4'd1;
            fis_done_d = eof;
            fis_len_d  = eof ? 4'd1 : fis_len_q;
            state_d    = eof ? IDLE : REG;
          end
        end
      end
      DATA: if (!empty) begin
        if (sof) begin
          fis_err_d = 1'b1;
          state_d   = HDR;
        end else if (bus.dat_ready && eof) begin
          fis_done_d = 1'b1;
          fis_len_d  = 4'd0;
          state_d    = IDLE;
        end
      end
      // truncation is checked before overflow so the next frame's header is never swallowed by DROP
      REG: if (!empty) begin
        if (sof) begin
          fis_err_d = 1'b1;
          state_d   = HDR;
        end else if (idx_full) begin
          fis_err_d = 1'b1;
          state_d   = DROP;
        end else begin
          reg_we_d   = 1'b1;
          reg_addr_d = idx_q[2:0];
          idx_d      = idx_q + 4'd1;
          fis_done_d = eof;
          fis_len_d  = eof ? idx_q + 4'd1 : fis_len_q;
          state_d    = eof ? IDLE : REG;
        end
      end
      DROP:  state_d = !empty && eof ? IDLE : DROP;
      FLUSH: state_d = empty ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = FLUSH;
      reg_we_d   = 1'b0;
      reg_addr_d = reg_addr_q;
      fis_type_d = fis_type_q;
      fis_len_d  = fis_len_q;
      fis_done_d = 1'b0;
      fis_err_d  = 1'b0;
    end
    fis_cnt_d = fis_cnt_q + {{(C_CNT_W-1){1'b0}}, fis_done_d};
    err_cnt_d = err_cnt_q + {{(C_CNT_W-1){1'b0}}, fis_err_d};
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 3'd0;
      reg_wdata_q <= 32'd0;
      fis_type_q  <= 8'd0;
      fis_len_q   <= 4'd0;
      fis_done_q  <= 1'b0;
      fis_err_q   <= 1'b0;
      fis_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      fis_type_q  <= fis_type_d;
      fis_len_q   <= fis_len_d;
      fis_done_q  <= fis_done_d;
      fis_err_q   <= fis_err_d;
      fis_cnt_q   <= fis_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule
